fir_out_quantizer: RTL and testbench



---
 rtl/fir_out_quantizer.sv | 128 ++++++++++++
 tb/tb_fir_out_quantizer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_out_quantizer.sv
// Captures FIR results on each fir_done rise and rescales them to saturated samples; ROUND_NEAREST_EN selects round-half-up over floor.
// Latency is 2 cycles from the capture edge to out_valid; a full FIFO drops new samples and sets sticky overflow.
module fir_out_quantizer #(
   parameter int IN_WIDTH  = 38,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 15,
   parameter int DEPTH     = 4,
   parameter int PTR_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  fir_in,
   input  logic                 fir_done,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_sat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PTR_W:0]       count,
   output logic                 overflow,
   input  logic                 clr_ovf
);

   localparam logic signed [IN_WIDTH:0] MAX_Q = (IN_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
   localparam logic signed [IN_WIDTH:0] MIN_Q = -MAX_Q - (IN_WIDTH+1)'(1);
   localparam logic [PTR_W:0]           FULL_CNT = (PTR_W+1)'(DEPTH);

   logic                 done_q;
   logic                 cap_v;
   logic [IN_WIDTH-1:0]  cap_reg;
   logic signed [IN_WIDTH:0] ext;
   logic signed [IN_WIDTH:0] q;
   logic [OUT_WIDTH-1:0] q_res;
   logic                 q_sat;
   logic [OUT_WIDTH-1:0] qreg;
   logic                 qsat;
   logic                 qv;

   logic [OUT_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]     sat_mem;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 pop;
   logic                 full;
   logic                 accept;
   logic                 drop;

   // Capture on the rising edge of fir_done only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q  <= 1'b0;
         cap_v   <= 1'b0;
         cap_reg <= '0;
      end else begin
         done_q <= fir_done;
         cap_v  <= fir_done & ~done_q;
         if (fir_done & ~done_q)
            cap_reg <= fir_in;
      end
   end

   always_comb begin
      ext   = {cap_reg[IN_WIDTH-1], cap_reg};
`ifdef ROUND_NEAREST_EN
      ext   = ext + (IN_WIDTH+1)'(2 ** (SHIFT-1));
`endif
      q     = ext >>> SHIFT;
      q_res = q[OUT_WIDTH-1:0];
      q_sat = 1'b0;
      if (q > MAX_Q) begin
         q_res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         q_sat = 1'b1;
      end else if (q < MIN_Q) begin
         q_res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         q_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qreg <= '0;
         qsat <= 1'b0;
         qv   <= 1'b0;
      end else begin
         qreg <= q_res;
         qsat <= q_sat;
         qv   <= cap_v;
      end
   end

   // A push into a full FIFO still lands if the head leaves in the same cycle
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign full      = (count == FULL_CNT);
   assign accept    = qv & (~full | pop);
   assign drop      = qv & full & ~pop;
   assign out_data  = mem[rd_ptr];
   assign out_sat   = sat_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         sat_mem  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr]     <= qreg;
            sat_mem[wr_ptr] <= qsat;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({accept, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: vector table through a scoreboard queue plus FIFO, overflow and reset corner sequences.
module tb_fir_out_quantizer;

`ifdef ROUND_NEAREST_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic signed [37:0] fir_in;
   logic               fir_done;
   logic [15:0]        out_data;
   logic               out_sat;
   logic               out_valid;
   logic               out_ready;
   logic [2:0]         count;
   logic               overflow;
   logic               clr_ovf;

   int n_cmp = 0;
   int n_bad = 0;
   logic [16:0] exp_q[$];

   typedef struct {
      logic signed [37:0] fin;
      logic [15:0]        d_trunc;
      logic [15:0]        d_round;
      logic               sat;
   } vec_t;
   vec_t vecs[12];

   fir_out_quantizer dut (
      .clk(clk), .rst(rst), .fir_in(fir_in), .fir_done(fir_done),
      .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
      .out_ready(out_ready), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: each accepted head sample must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {47'd0, out_sat, out_data}, 64'h1_0000_0000);
         end else begin
            chk("pop_sample", {47'd0, out_sat, out_data}, {47'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic pulse(input logic signed [37:0] v, input logic [15:0] d, input logic s, input bit expect_it);
      @(posedge clk); #1;
      fir_in   = v;
      fir_done = 1'b1;
      if (expect_it) exp_q.push_back({s, d});
      @(posedge clk); #1;
      fir_done = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int budget;
      @(posedge clk); #1;
      out_ready = 1'b1;
      budget = 0;
      while ((exp_q.size() != 0 || count != 0) && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_count0"}, 64'(count), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{38'sd98304,            16'h0003, 16'h0003, 1'b0};
      vecs[1]  = '{38'sd180224,           16'h0005, 16'h0006, 1'b0};
      vecs[2]  = '{-38'sd1,               16'hFFFF, 16'h0000, 1'b0};
      vecs[3]  = '{38'sd2147483648,       16'h7FFF, 16'h7FFF, 1'b1};
      vecs[4]  = '{-38'sd2147483648,      16'h8000, 16'h8000, 1'b1};
      vecs[5]  = '{38'sd32767,            16'h0000, 16'h0001, 1'b0};
      vecs[6]  = '{-38'sd32768,           16'hFFFF, 16'hFFFF, 1'b0};
      vecs[7]  = '{38'sd1073709056,       16'h7FFF, 16'h7FFF, 1'b0};
      vecs[8]  = '{38'sd1073741824,       16'h7FFF, 16'h7FFF, 1'b1};
      vecs[9]  = '{-38'sd1073741824,      16'h8000, 16'h8000, 1'b0};
      vecs[10] = '{-38'sd1073774592,      16'h8000, 16'h8000, 1'b1};
      vecs[11] = '{38'sd137438953471,     16'h7FFF, 16'h7FFF, 1'b1};

      rst = 1'b1; fir_in = '0; fir_done = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      cycles(3);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_sat", 64'(out_sat), 64'd0);
      rst = 1'b0;
      cycles(2);

      // Latency: capture edge E, qreg at E+1, visible after E+2
      pulse(38'sd98304, 16'h0003, 1'b0, 1'b1);
      @(negedge clk);
      chk("lat_e0_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_e1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_e2_valid", 64'(out_valid), 64'd1);
      chk("lat_e2_count", 64'(count), 64'd1);
      chk("lat_e2_data", 64'(out_data), 64'h0003);
      chk("lat_e2_sat", 64'(out_sat), 64'd0);
      drain("latency");

      // Table, back-to-back at minimum done spacing
      for (int i = 0; i < 12; i++)
         pulse(vecs[i].fin, RND ? vecs[i].d_round : vecs[i].d_trunc, vecs[i].sat, 1'b1);
      drain("table");

      // Overflow: 5 pulses into 4 entries, fifth lost
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++)
         pulse(38'(k * 32768), 16'(k), 1'b0, k <= 4);
      cycles(3);
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_held_data", 64'(out_data), 64'd1);
      drain("ovf");
      chk("ovf_sticky", 64'(overflow), 64'd1);
      clr_ovf = 1'b1;
      cycles(1);
      clr_ovf = 1'b0;
      chk("ovf_cleared", 64'(overflow), 64'd0);

      // Full FIFO: write of a new sample coincides with a pop
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++)
         pulse(38'(k * 32768 + 100), 16'(k), 1'b0, 1'b1);
      cycles(3);
      chk("full_count", 64'(count), 64'd4);
      @(posedge clk); #1;
      fir_in = 38'sd229376; fir_done = 1'b1;
      exp_q.push_back({1'b0, 16'd7});
      @(posedge clk); #1;
      fir_done = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("full_pop_push_count", 64'(count), 64'd4);
      chk("full_pop_push_ovf", 64'(overflow), 64'd0);
      drain("fullpop");

      // Held-high done yields a single capture
      out_ready = 1'b0;
      @(posedge clk); #1;
      fir_in = 38'sd294912; fir_done = 1'b1;
      cycles(10);
      fir_done = 1'b0;
      cycles(3);
      chk("held_done_count", 64'(count), 64'd1);
      chk("held_done_data", 64'(out_data), 64'd9);

      // Reset with three buffered and one in flight
      pulse(38'sd327680, 16'd10, 1'b0, 1'b0);
      pulse(38'sd360448, 16'd11, 1'b0, 1'b0);
      cycles(2);
      chk("pre_rst_count", 64'(count), 64'd3);
      pulse(38'sd393216, 16'd12, 1'b0, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      cycles(1);
      rst = 1'b0;
      out_ready = 1'b1;
      cycles(8);
      chk("post_rst_count", 64'(count), 64'd0);
      chk("post_rst_valid", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
